lcd_timing_gen: RTL

Parametrised LCD timing and pin-control generator, successor to the fixed-timing LCD control page. Owns the horizontal/vertical dot counters and drives the active-low panel pins (CPL, FR, ST, S) and the pixel-pipe clock enable. Adds configurable geometry, two FR inversion modes, pixel-stall handling and overrun detection. Sits between the video register file (LCD enable, debug pin sources) and the pixel fetcher/FIFO.

---
 rtl/lcd_timing_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: dot/line counters, active-low panel pins,
// pixel-pipe enable with stall handling and sticky overrun detection.
module lcd_timing_gen #(
  parameter int H_W       = 9,
  parameter int V_W       = 8,
  parameter int H_TOTAL   = 456,
  parameter int V_TOTAL   = 154,
  parameter int H_ACTIVE  = 160,
  parameter int V_ACTIVE  = 144,
  parameter int PIX_START = 80,
  parameter int CPL_WIDTH = 2,
  parameter int FR_MODE   = 0,
  parameter int FR_LINES  = 1
) (
  input  logic           clk2,
  input  logic           nreset_video,
  input  logic           lcd_en,
  input  logic           pix_valid,
  input  logic           dbg_cpl,
  input  logic           dbg_fr,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           vblank,
  output logic           line_end,
  output logic           frame_end,
  output logic           clkpipe,
  output logic           npin_cpl,
  output logic           npin_fr,
  output logic           npin_st,
  output logic           npin_s,
  output logic           overrun
);

  localparam int PX_W = $clog2(H_ACTIVE + 1);
  localparam int LC_W = (FR_LINES > 1) ? $clog2(FR_LINES) : 1;

  localparam logic [H_W-1:0]  H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]  H_ARM   = H_W'(PIX_START - 1);
  localparam logic [H_W-1:0]  H_CPL   = H_W'(CPL_WIDTH);
  localparam logic [V_W-1:0]  V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]  V_VIS   = V_W'(V_ACTIVE);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(H_ACTIVE - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(FR_LINES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic            en_q, en_d;
  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;
  logic            fr_q, fr_d;
  logic [LC_W-1:0] lc_q, lc_d;
  logic [1:0]      state_q, state_d;
  logic [PX_W-1:0] px_q, px_d;
  logic            st_q, st_d;
  logic            overrun_q, overrun_d;

  logic run, at_line_end, at_frame_end, pix_fire, last_px, fr_toggle;

  // en_q delays counting by one edge so the first enabled clock shows dot 0
  assign run          = lcd_en && en_q;
  assign at_line_end  = (h_q == H_LAST);
  assign at_frame_end = at_line_end && (v_q == V_LAST);
  assign pix_fire     = (state_q == S_EMIT) && pix_valid;
  assign last_px      = pix_fire && (px_q == PX_LAST);
  assign fr_toggle    = (FR_MODE == 0) ? (lc_q == LC_LAST) : at_frame_end;

  always_comb begin
    en_d      = en_q;
    h_d       = h_q;
    v_d       = v_q;
    fr_d      = fr_q;
    lc_d      = lc_q;
    state_d   = state_q;
    px_d      = px_q;
    st_d      = st_q;
    overrun_d = overrun_q;
    if (!lcd_en) begin
      en_d      = 1'b0;
      h_d       = '0;
      v_d       = '0;
      fr_d      = 1'b0;
      lc_d      = '0;
      state_d   = S_IDLE;
      px_d      = '0;
      st_d      = 1'b0;
      overrun_d = 1'b0;
    end else if (!en_q) begin
      en_d = 1'b1;
    end else begin
      h_d = at_line_end ? '0 : h_q + 1'b1;
      if (at_line_end) begin
        v_d  = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        fr_d = fr_q ^ fr_toggle;
        lc_d = (at_frame_end || lc_q == LC_LAST) ? '0 : lc_q + 1'b1;
      end
      case (state_q)
        S_IDLE: if (h_q == '0 && v_q < V_VIS) state_d = S_WAIT;
        S_WAIT: if (h_q == H_ARM) state_d = S_EMIT;
        S_EMIT: begin
          if (pix_fire) begin
            if (px_q == '0) st_d = 1'b1;
            if (last_px) begin
              state_d = S_DONE;
              px_d    = '0;
            end else begin
              px_d = px_q + 1'b1;
            end
          end
        end
        S_DONE:  st_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
      // Line end always returns to IDLE; a last pixel landing on it still counts as complete
      if (at_line_end && state_q != S_IDLE) begin
        if (state_q != S_DONE && !last_px) overrun_d = 1'b1;
        state_d = S_IDLE;
        px_d    = '0;
        st_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk2 or negedge nreset_video) begin
    if (!nreset_video) begin
      en_q      <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      fr_q      <= 1'b0;
      lc_q      <= '0;
      state_q   <= S_IDLE;
      px_q      <= '0;
      st_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      h_q       <= h_d;
      v_q       <= v_d;
      fr_q      <= fr_d;
      lc_q      <= lc_d;
      state_q   <= state_d;
      px_q      <= px_d;
      st_q      <= st_d;
      overrun_q <= overrun_d;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign vblank    = (v_q >= V_VIS);
  assign line_end  = run && at_line_end;
  assign frame_end = run && at_frame_end;
  assign clkpipe   = run && pix_fire;
  assign npin_cpl  = run ? (h_q >= H_CPL) : ~dbg_cpl;
  assign npin_fr   = run ? ~fr_q : ~dbg_fr;
  assign npin_st   = ~(run && st_q);
  assign npin_s    = ~(run && (v_q == '0));
  assign overrun   = overrun_q;

endmodule
